// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, jump/branch redirect and a local instruction memory.
// Optional HALT detection is compiled in when IF_HALT_DETECT_EN is defined.
module if_stage #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic                          jump_en,
  input  logic [25:0]                   jump_target,
  input  logic                          branch_en,
  input  logic [31:0]                   branch_pc,
  input  logic [15:0]                   branch_offset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   instruction,
  output logic [31:0]                   pc_out,
  output logic                          valid,
  output logic                          halted
);
  localparam int AW = $clog2(IMEM_DEPTH);
`ifdef IF_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  logic [31:0]   imem_r [IMEM_DEPTH];
  logic [31:0]   pc_r, pc_nxt_s;
  logic [31:0]   instr_r, instr_nxt_s;
  logic [31:0]   pc_out_r, pc_out_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic          halted_r, halted_nxt_s;
  logic [AW-1:0] fetch_idx_s;
  logic [31:0]   fetch_word_s;
  logic [3:0]    jump_hi_s;
  logic [31:0]   jump_pc_s;
  logic [31:0]   branch_pc_s;

  function automatic logic is_halt_word(input logic [5:0] opcode);
    return HALT_EN && (opcode == 6'b111111);
  endfunction

  function automatic logic [31:0] branch_dest(input logic [31:0] bpc, input logic [15:0] off);
    return bpc + 32'd4 + {{14{off[15]}}, off, 2'b00};
  endfunction

  assign fetch_idx_s  = pc_r[AW+1:2];
  assign fetch_word_s = imem_r[fetch_idx_s];
  // Upper nibble of pc_out+4: adding 4 carries into bit 28 only when bits [27:2] are all ones.
  assign jump_hi_s    = pc_out_r[31:28] + {3'b000, &pc_out_r[27:2]};
  assign jump_pc_s    = {jump_hi_s, jump_target, 2'b00};
  assign branch_pc_s  = branch_dest(branch_pc, branch_offset);

  // Next-state selection: halt freeze, then jump, branch, stall, advance.
  always_comb begin
    pc_nxt_s     = pc_r;
    instr_nxt_s  = instr_r;
    pc_out_nxt_s = pc_out_r;
    valid_nxt_s  = valid_r;
    halted_nxt_s = halted_r;
    if (halted_r) begin
      if (!stall) begin
        valid_nxt_s = 1'b0;
      end else begin
        valid_nxt_s = valid_r;
      end
    end else if (jump_en) begin
      pc_nxt_s    = jump_pc_s;
      valid_nxt_s = 1'b0;
    end else if (branch_en) begin
      pc_nxt_s    = branch_pc_s;
      valid_nxt_s = 1'b0;
    end else if (stall) begin
      pc_nxt_s    = pc_r;
      valid_nxt_s = valid_r;
    end else begin
      instr_nxt_s  = fetch_word_s;
      pc_out_nxt_s = pc_r;
      valid_nxt_s  = 1'b1;
      pc_nxt_s     = pc_r + 32'd4;
      halted_nxt_s = is_halt_word(fetch_word_s[31:26]);
    end
  end

  // Fetch state and presented outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC;
      instr_r  <= 32'h0000_0000;
      pc_out_r <= 32'h0000_0000;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      pc_r     <= pc_nxt_s;
      instr_r  <= instr_nxt_s;
      pc_out_r <= pc_out_nxt_s;
      valid_r  <= valid_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  // Instruction memory write port; contents survive reset, reads see the pre-write word.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_r[imem_waddr] <= imem_wdata;
    end
  end

  assign instruction = instr_r;
  assign pc_out      = pc_out_r;
  assign valid       = valid_r;
  assign halted      = halted_r;

endmodule
